// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and the Power2Round control-state encoding.
package dilithium_pkg;

  localparam int Q      = 8380417;
  localparam int D      = 13;
  localparam int N      = 256;
  localparam int K      = 6;
  localparam int COEF_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } p2r_state_e;

endpackage

// File: rtl/power2round.sv
// Combinational Power2Round of one coefficient: a = t1*2^D + t0, t0 in (-2^(D-1), 2^(D-1)].
module power2round
  import dilithium_pkg::*;
#(
  parameter int DATA_W = COEF_W
) (
  input  logic signed [DATA_W-1:0] a,
  output logic signed [DATA_W-1:0] t1,
  output logic signed [DATA_W-1:0] t0
);

  // Round-half-down to the nearest multiple of 2^D, done in wrapping 32-bit arithmetic.
  function automatic logic signed [DATA_W-1:0] round_hi(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] bias;
    bias = DATA_W'((1 << (D - 1)) - 1);
    return (x + bias) >>> D;
  endfunction

  function automatic logic signed [DATA_W-1:0] low_part(input logic signed [DATA_W-1:0] x,
                                                         input logic signed [DATA_W-1:0] hi);
    return x - (hi <<< D);
  endfunction

  assign t1 = round_hi(a);
  assign t0 = low_part(a, t1);

endmodule

// File: rtl/polyveck_power2round.sv
// Splits every coefficient of a K-polynomial vector into t1/t0, LANES coefficients per cycle.
module polyveck_power2round
  import dilithium_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int DATA_W = COEF_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_W*K*N-1:0]     linear_v_in,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_W*K*N-1:0]     linear_t1_out,
  output logic [DATA_W*K*N-1:0]     linear_t0_out
);

  localparam int TOTAL   = K * N;
  localparam int IDX_W   = $clog2(TOTAL);
  localparam int BUS_W   = DATA_W * TOTAL;
  localparam int OFF_W   = $clog2(BUS_W);
  localparam int CHUNK_W = LANES * DATA_W;
  localparam int LAST    = TOTAL - LANES;

  p2r_state_e       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             vld_p0;
  logic [OFF_W-1:0] off_p0;
  logic [CHUNK_W-1:0] chunk_p0, t1_p0, t0_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          idx_nxt   = '0;
        end
      end
      ST_RUN: begin
        idx_nxt = idx + IDX_W'(LANES);
        if (idx == IDX_W'(LAST)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != ST_IDLE);
    done   = (state == ST_DONE);
    vld_p0 = (state == ST_RUN);
  end

  // Stage p0: select the current chunk and split each lane combinationally.
  assign off_p0   = OFF_W'(idx) * OFF_W'(DATA_W);
  assign chunk_p0 = linear_v_in[off_p0 +: CHUNK_W];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    power2round #(.DATA_W(DATA_W)) u_p2r (
      .a  (chunk_p0[g*DATA_W +: DATA_W]),
      .t1 (t1_p0[g*DATA_W +: DATA_W]),
      .t0 (t0_p0[g*DATA_W +: DATA_W])
    );
  end

  // Stage p1: chunk results land in the output registers at the processed position.
  always_ff @(posedge clk) begin
    if (rst) begin
      linear_t1_out <= '0;
      linear_t0_out <= '0;
    end else if (vld_p0) begin
      linear_t1_out[off_p0 +: CHUNK_W] <= t1_p0;
      linear_t0_out[off_p0 +: CHUNK_W] <= t0_p0;
    end
  end

endmodule

// File: tb/tb_polyveck_power2round.sv
// Self-checking bench for polyveck_power2round: boundary table, handshake, reset and random runs.
module tb_polyveck_power2round;
  import dilithium_pkg::*;

  localparam int TOTAL   = K * N;
  localparam int BUS_W   = 32 * TOTAL;
  localparam int RUN_LAT = TOTAL / 8 + 1;

  logic             clk = 1'b0;
  logic             rst, start, busy, done;
  logic [BUS_W-1:0] vin, t1o, t0o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int a;
    int t1;
    int t0;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  polyveck_power2round #(.LANES(8), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .linear_v_in   (vin),
    .busy          (busy),
    .done          (done),
    .linear_t1_out (t1o),
    .linear_t0_out (t0o)
  );

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: t1 = floor((a + 2^12 - 1) / 2^13), t0 = a - t1 * 2^13.
  function automatic longint model_t1(input longint a);
    longint s;
    s = a + 4095;
    if (s >= 0) return s / 8192;
    return -((-s + 8191) / 8192);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < TOTAL; i++) begin
      case ($urandom_range(15, 0))
        0:       vin[i*32 +: 32] = 32'(Q - 1);
        1:       vin[i*32 +: 32] = 32'd0;
        default: vin[i*32 +: 32] = 32'($urandom_range(Q - 1, 0));
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    logic signed [31:0] a32, g1, g0;
    longint e1;
    for (int i = 0; i < TOTAL; i++) begin
      a32 = vin[i*32 +: 32];
      g1  = t1o[i*32 +: 32];
      g0  = t0o[i*32 +: 32];
      e1  = model_t1(longint'(a32));
      check($sformatf("%s t1[%0d]", tag, i), longint'(g1), e1);
      check($sformatf("%s t0[%0d]", tag, i), longint'(g0), longint'(a32) - e1 * 8192);
      check($sformatf("%s inv[%0d]", tag, i), longint'(g1) * 8192 + longint'(g0), longint'(a32));
    end
  endtask

  // Called just after start was raised on a falling edge (cycle 0).
  task automatic wait_done(input string tag, input int exp_cyc);
    int c;
    bit seen;
    c    = 0;
    seen = 1'b0;
    while (c < exp_cyc + 20 && !seen) begin
      @(negedge clk);
      c++;
      if (c == 1) start = 1'b0;
      if (done) seen = 1'b1;
    end
    check({tag, " done seen"}, longint'(seen), 1);
    check({tag, " done cycle"}, c, exp_cyc);
  endtask

  initial begin
    bit seen;
    logic signed [31:0] g1, g0;

    tbl[0] = '{0, 0, 0};
    tbl[1] = '{4096, 0, 4096};
    tbl[2] = '{4097, 1, -4095};
    tbl[3] = '{8191, 1, -1};
    tbl[4] = '{8380416, 1023, 0};

    rst   = 1'b1;
    start = 1'b0;
    vin   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset t1 zero", longint'(t1o == '0), 1);
    check("reset t0 zero", longint'(t0o == '0), 1);

    // Boundary run, stray start at 50, back-to-back second run at 194.
    for (int i = 0; i < TOTAL; i++) vin[i*32 +: 32] = 32'(tbl[i % 5].a);
    start = 1'b1;
    for (int c = 1; c <= 388; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      check($sformatf("busy@%0d", c), busy,
            ((c <= 193) || (c >= 195 && c <= 387)) ? 1 : 0);
      check($sformatf("done@%0d", c), done, (c == 193 || c == 387) ? 1 : 0);
      if (c == 193) begin
        for (int i = 0; i < TOTAL; i++) begin
          g1 = t1o[i*32 +: 32];
          g0 = t0o[i*32 +: 32];
          check($sformatf("bnd t1[%0d] a=%0d", i, tbl[i % 5].a), longint'(g1), tbl[i % 5].t1);
          check($sformatf("bnd t0[%0d] a=%0d", i, tbl[i % 5].a), longint'(g0), tbl[i % 5].t0);
        end
      end
      if (c == 50) start = 1'b1;
      if (c == 51) start = 1'b0;
      if (c == 194) begin
        fill_random();
        start = 1'b1;
      end
      if (c == 195) start = 1'b0;
      if (c == 387) check_outputs("b2b");
    end

    // Reset in the middle of a run.
    fill_random();
    start = 1'b1;
    for (int c = 1; c <= 101; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 100) rst = 1'b1;
    end
    rst = 1'b0;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst t1 zero", longint'(t1o == '0), 1);
    check("midrst t0 zero", longint'(t0o == '0), 1);
    seen = 1'b0;
    repeat (250) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midrst no done", longint'(seen), 0);

    // Reset and start together: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst+start busy", busy, 0);
    @(negedge clk);
    check("rst+start idle", busy, 0);

    fill_random();
    start = 1'b1;
    wait_done("post-reset", RUN_LAT);
    check_outputs("post-reset");

    // Random regression runs.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      fill_random();
      start = 1'b1;
      wait_done($sformatf("rand%0d", r), RUN_LAT);
      check_outputs($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/polyveck_power2round.md
# polyveck_power2round

Multi-cycle stage directly downstream of `polyveck_caddq` in key generation. It takes the K-polynomial vector t, with every coefficient already in [0, q), and splits each coefficient into high bits t1 and low bits t0 (Dilithium Power2Round, D = 13). Coefficients are processed LANES at a time under a start/done handshake. t1 feeds the public-key packer and t0 feeds the secret-key packer.

## Interface
- K, 6, polynomials per vector
- N, 256, coefficients per polynomial
- LANES, 8, coefficients processed per cycle; must divide K·N
- D, 13, dropped bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- linear_v_in  in  32·K·N (49152)  caddq output, coefficient i at bits [32i+31:32i], signed 32-bit, values in [0, q); must be stable from the start cycle until done
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; results complete
- linear_t1_out  out  49152  registered t1 coefficients, same packing, signed 32-bit, values 0..1023
- linear_t0_out  out  49152  registered t0 coefficients, same packing, signed 32-bit, values in (−4096, 4096]

## Operation
- Per coefficient a:
  - t1 = (a + 2^(D−1) − 1) >>> D
  - t0 = a − (t1 << D)
  - Full 32-bit signed arithmetic; no saturation.
- FSM states:
  - IDLE: start=1 → RUN, idx←0.
  - RUN: write coefficients idx..idx+LANES−1 to both output buses, then idx←idx+LANES. When idx = K·N−LANES, go to DONE after the write.
  - DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored; no queuing.
- Outputs hold their last values in IDLE.
- A new run overwrites outputs progressively. Outputs are valid only from done until the next accepted start.
- Input out of range (negative or ≥ q) is not checked. Results follow the formula bit-exactly.

## Timing
- Reset values:
  - state=IDLE, idx=0, busy=0, done=0
  - linear_t1_out=0, linear_t0_out=0
- Latency with start at cycle 0:
  - RUN covers cycles 1..K·N/LANES (1..192).
  - done=1 at cycle K·N/LANES+1 (193).
  - busy=1 over cycles 1..193.
  - Next start is accepted at cycle 194 at the earliest.
- Each RUN cycle registers exactly LANES coefficients. Results for the chunk appear on the outputs the cycle after it is processed.
- Reset during RUN or DONE: next cycle is IDLE, outputs are zeroed, and no done pulse is produced.
- Reset and start asserted together: reset wins.

## Structure
- Shared package `dilithium_pkg`: Q = 8380417, D, N, K, and the 32-bit coefficient width.
- Sub-module `power2round`: combinational, one coefficient, 32-bit in, t1/t0 out. Instantiated LANES times.
- idx counter width: clog2(K·N).
- Lane selection from linear_v_in uses an indexed part-select on idx.

## Test plan
- Boundary values: coefficient 0 → t1=0, t0=0; 4096 → t1=0, t0=4096; 4097 → t1=1, t0=−4095; 8191 → t1=1, t0=−1; 8380416 → t1=1023, t0=0. Place one value in each polynomial and compare all 1536 lanes.
- Handshake: after a single start, done pulses exactly at cycle 193, busy is high over cycles 1..193, and a start issued at cycle 50 has no effect.
- Back-to-back runs: start a second run at cycle 194 with new input. The second done arrives at cycle 387, and the outputs match the new input.
- Reset mid-run: assert rst at cycle 100. Outputs read 0 and state is IDLE the next cycle, no done appears, and a following start completes normally.
- Random regression: 1000 random vectors with coefficients uniform in [0, q). Compare against the C reference power2round, and check the invariant t1·2^13 + t0 = a for every coefficient.
